alu_operand_sequencer: RTL and testbench

//  Micro-sequencer for the ALU operand-select mux (ALUMUX: 001 IR, 101 R5, 100 R1, 010 IDX, 011 IDY).

---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_operand_sequencer.sv | 116 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// alu_seq_pkg : ALUMUX codes, op codes, state encoding and the op table
// Revision    : 1.0
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_IR   = 3'b001;
    localparam logic [2:0] SEL_IDX  = 3'b010;
    localparam logic [2:0] SEL_IDY  = 3'b011;
    localparam logic [2:0] SEL_R1   = 3'b100;
    localparam logic [2:0] SEL_R5   = 3'b101;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LDIR   = 3'd1;
    localparam logic [2:0] OP_ADDR1  = 3'd2;
    localparam logic [2:0] OP_ADDR5  = 3'd3;
    localparam logic [2:0] OP_LDIDX  = 3'd4;
    localparam logic [2:0] OP_LDIDY  = 3'd5;
    localparam logic [2:0] OP_ADDXY  = 3'd6;
    localparam logic [2:0] OP_ADDIR1 = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [1:0] op_steps(input logic [2:0] op);
        case (op)
            OP_NOP:               op_steps = 2'd0;
            OP_ADDXY, OP_ADDIR1:  op_steps = 2'd2;
            default:              op_steps = 2'd1;
        endcase
    endfunction

    function automatic logic [2:0] op_sel(input logic [2:0] op, input logic step);
        case (op)
            OP_LDIR:   op_sel = SEL_IR;
            OP_ADDR1:  op_sel = SEL_R1;
            OP_ADDR5:  op_sel = SEL_R5;
            OP_LDIDX:  op_sel = SEL_IDX;
            OP_LDIDY:  op_sel = SEL_IDY;
            OP_ADDXY:  op_sel = step ? SEL_IDY : SEL_IDX;
            OP_ADDIR1: op_sel = step ? SEL_R1 : SEL_IR;
            default:   op_sel = SEL_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// alu_operand_sequencer : steps the ALU operand mux through 1-2 selects per op
// Revision              : 1.0
// ============================================================================
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    output logic       req_ready,
    input  logic       abort,
    output logic [2:0] alumux,
    output logic       alu_en,
    output logic       acc_load,
    output logic       busy,
    output logic       done
);

    localparam int            CW       = $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    logic [1:0]    r_state;
    logic [2:0]    r_op;
    logic          r_step;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_state_nxt;
    logic [2:0]    w_op_nxt;
    logic          w_step_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic          w_last_step;

    // req_ready is the only output with a combinational path (from rst)
    assign req_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = req_valid && req_ready;
    assign w_last_step = !((op_steps(r_op) == 2'd2) && (r_step == 1'b0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_step  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_op_nxt    = req_op;
                    w_step_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (op_steps(req_op) != 2'd0) ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WB;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WB: begin
                if (w_last_step) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step_nxt  = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Flush kills whatever follows; the current cycle's outputs are unaffected
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = 1'b0;
            w_cnt_nxt   = '0;
        end
    end

    always_comb begin
        alumux   = SEL_NONE;
        alu_en   = 1'b0;
        acc_load = 1'b0;
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        if ((r_state == ST_EXEC) || (r_state == ST_WB)) begin
            alumux = op_sel(r_op, r_step);
        end
        if (r_state == ST_EXEC) begin
            alu_en = 1'b1;
        end
        if (r_state == ST_WB) begin
            acc_load = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_operand_sequencer : directed table, corner sequences, random vs model
// Revision                 : 1.0
// ============================================================================
module tb_alu_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, valid1, abort1, ready1, en1, load1, busy1, done1;
    logic [2:0] op1, mux1;
    logic       rst3, valid3, abort3, ready3, en3, load3, busy3, done3;
    logic [2:0] op3, mux3;

    alu_operand_sequencer #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(valid1), .req_op(op1), .req_ready(ready1),
        .abort(abort1), .alumux(mux1), .alu_en(en1), .acc_load(load1),
        .busy(busy1), .done(done1)
    );

    alu_operand_sequencer #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(valid3), .req_op(op3), .req_ready(ready3),
        .abort(abort3), .alumux(mux3), .alu_en(en3), .acc_load(load3),
        .busy(busy3), .done(done3)
    );

    int total = 0;
    int bad   = 0;

    // Op table as the behavioural model sees it
    int         steps_tbl [8] = '{0, 1, 1, 1, 1, 1, 2, 2};
    logic [2:0] sel0_tbl  [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b010, 3'b001};
    logic [2:0] sel1_tbl  [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b100};

    typedef struct {
        logic [2:0] op;
        int         lat;
        int         loads;
        logic [2:0] mux;
    } vec_t;
    vec_t tbl [8];

    logic [7:0] etr [0:1023];

    // Observation vector: {ready, alumux[2:0], alu_en, acc_load, busy, done}
    function automatic logic [7:0] obs(input int L);
        if (L == 1) return {ready1, mux1, en1, load1, busy1, done1};
        return {ready3, mux3, en3, load3, busy3, done3};
    endfunction

    task automatic drive(input int L, input logic v, input logic [2:0] o, input logic ab);
        if (L == 1) begin
            valid1 = v; op1 = o; abort1 = ab;
        end else begin
            valid3 = v; op3 = o; abort3 = ab;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_random(input int L, input int n);
        int         free_at;
        logic       v, ab;
        logic [2:0] o;
        logic [7:0] e;
        int         k;
        logic [2:0] sel;
        free_at = 0;
        for (int i = 0; i < 1024; i++) etr[i] = 8'h00;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = etr[c] | ((c >= free_at) ? 8'h80 : 8'h00);
            chk($sformatf("rand_L%0d_c%0d", L, c), obs(L), e);
            v  = ($urandom % 3) != 0;
            o  = 3'($urandom % 8);
            ab = ($urandom % 12) == 0;
            if (c >= n - 16) begin
                v  = 1'b0;
                ab = 1'b0;
            end
            drive(L, v, o, ab);
            if (c >= free_at) begin
                if (v) begin
                    k = steps_tbl[o];
                    for (int s = 0; s < k; s++) begin
                        sel = (s == 0) ? sel0_tbl[o] : sel1_tbl[o];
                        for (int j = 1; j <= L; j++)
                            etr[c + s * (L + 1) + j] = {1'b0, sel, 4'b1010};
                        etr[c + (s + 1) * (L + 1)] = {1'b0, sel, 4'b0110};
                    end
                    etr[c + k * (L + 1) + 1] = 8'b0000_0011;
                    free_at = c + k * (L + 1) + 2;
                end
            end else if (ab) begin
                for (int i = c + 1; i < 1024; i++) etr[i] = 8'h00;
                free_at = c + 1;
            end
        end
        drive(L, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] o;
        int         lat, loads;
        logic [2:0] first;
        logic       got;
        logic [7:0] exp5 [10];

        rst1 = 1'b1; rst3 = 1'b1;
        drive(1, 1'b0, 3'd0, 1'b0);
        drive(3, 1'b0, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_L1", obs(1), 8'h00);
        chk("reset_L3", obs(3), 8'h00);
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        chk("post_reset_L1", obs(1), 8'h80);
        chk("post_reset_L3", obs(3), 8'h80);

        // Latency = cycles from handshake to done; ALU_LAT=1 gives 2k+1, NOP gives 1
        tbl[0] = '{3'd0, 1, 0, 3'b000};
        tbl[1] = '{3'd1, 3, 1, 3'b001};
        tbl[2] = '{3'd2, 3, 1, 3'b100};
        tbl[3] = '{3'd3, 3, 1, 3'b101};
        tbl[4] = '{3'd4, 3, 1, 3'b010};
        tbl[5] = '{3'd5, 3, 1, 3'b011};
        tbl[6] = '{3'd6, 5, 2, 3'b010};
        tbl[7] = '{3'd7, 5, 2, 3'b001};
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'b1, tbl[i].op, 1'b0);
            @(negedge clk);
            drive(1, 1'b0, 3'd0, 1'b0);
            lat = 99; loads = 0; first = 3'b000; got = 1'b0;
            for (int n = 1; n <= 20; n++) begin
                o = obs(1);
                if (o[3] && !got) begin
                    first = o[6:4];
                    got   = 1'b1;
                end
                if (o[2]) loads++;
                if (o[0]) begin
                    lat = n;
                    break;
                end
                @(negedge clk);
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_lat", i), 8'(lat), 8'(tbl[i].lat));
            chk($sformatf("tbl%0d_loads", i), 8'(loads), 8'(tbl[i].loads));
            chk($sformatf("tbl%0d_mux", i), {5'd0, first}, {5'd0, tbl[i].mux});
            chk($sformatf("tbl%0d_ready_after", i), obs(1), 8'h80);
        end

        // NOP with LDIR queued behind it on a held valid
        drive(1, 1'b1, 3'd0, 1'b0);
        @(negedge clk); chk("nop_done", obs(1), 8'b0000_0011);
        drive(1, 1'b1, 3'd1, 1'b0);
        @(negedge clk); chk("nop_ready", obs(1), 8'h80);
        @(negedge clk); chk("ldir_exec", obs(1), 8'b0001_1010);
        drive(1, 1'b0, 3'd0, 1'b0);
        @(negedge clk); chk("ldir_wb", obs(1), 8'b0001_0110);
        @(negedge clk); chk("ldir_done", obs(1), 8'b0000_0011);
        @(negedge clk); chk("ldir_idle", obs(1), 8'h80);

        // ADDXY aborted during its second EXEC
        drive(1, 1'b1, 3'd6, 1'b0);
        @(negedge clk); chk("abort_exec0", obs(1), 8'b0010_1010);
        drive(1, 1'b0, 3'd0, 1'b0);
        @(negedge clk); chk("abort_wb0", obs(1), 8'b0010_0110);
        @(negedge clk); chk("abort_exec1", obs(1), 8'b0011_1010);
        drive(1, 1'b0, 3'd0, 1'b1);
        @(negedge clk); chk("abort_idle", obs(1), 8'h80);
        drive(1, 1'b0, 3'd0, 1'b0);
        @(negedge clk); chk("abort_no_done", obs(1), 8'h80);

        // Reset during the WB cycle of ADDR5
        drive(1, 1'b1, 3'd3, 1'b0);
        @(negedge clk); chk("rst_exec", obs(1), 8'b0101_1010);
        drive(1, 1'b0, 3'd0, 1'b0);
        @(negedge clk); chk("rst_wb", obs(1), 8'b0101_0110);
        rst1 = 1'b1;
        @(negedge clk); chk("rst_killed0", obs(1), 8'h00);
        @(negedge clk); chk("rst_killed1", obs(1), 8'h00);
        rst1 = 1'b0;
        @(negedge clk); chk("rst_ready", obs(1), 8'h80);
        @(negedge clk); chk("rst_no_done", obs(1), 8'h80);

        // ADDIR1 with ALU_LAT=3
        exp5 = '{8'b0001_1010, 8'b0001_1010, 8'b0001_1010, 8'b0001_0110,
                 8'b0100_1010, 8'b0100_1010, 8'b0100_1010, 8'b0100_0110,
                 8'b0000_0011, 8'h80};
        drive(3, 1'b1, 3'd7, 1'b0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            drive(3, 1'b0, 3'd0, 1'b0);
            chk($sformatf("lat3_c%0d", n + 1), obs(3), exp5[n]);
        end

        run_random(1, 400);
        run_random(3, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
